// File: rtl/dual_stream_pkg.sv
// Shared types and default geometry for the dual-stream line FIFO read side.
package dual_stream_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SOF  = 3'd1,
    WAIT_LINE = 3'd2,
    READ      = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam int DEF_LINE_W  = 1920;
  localparam int DEF_FRAME_H = 1080;
  localparam int DEF_HBLANK  = 50;

endpackage

// File: rtl/sof_pair_sync.sv
// Pairs the two channels' start-of-frame pulses within a skew window.
// both_sof is combinational so the scheduler can act on the completing pulse itself.
module sof_pair_sync #(
  parameter int CWIDTH   = 12,
  parameter int SKEW_MAX = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic sof1,
  input  logic sof2,
  output logic both_sof,
  output logic skew_err
);

  localparam logic [CWIDTH-1:0] SKEW_C = CWIDTH'(SKEW_MAX);

  logic              seen1;
  logic              seen2;
  logic [CWIDTH-1:0] skew_cnt;

  assign both_sof = active & (seen1 | sof1) & (seen2 | sof2);

  // skew_cnt holds the number of edges since the first SOF was latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen1    <= 1'b0;
      seen2    <= 1'b0;
      skew_cnt <= '0;
      skew_err <= 1'b0;
    end else if (!active || both_sof) begin
      seen1    <= 1'b0;
      seen2    <= 1'b0;
      skew_cnt <= '0;
    end else if (seen1 ^ seen2) begin
      if (skew_cnt == SKEW_C) begin
        skew_err <= 1'b1;
        seen1    <= 1'b0;
        seen2    <= 1'b0;
        skew_cnt <= '0;
      end else begin
        skew_cnt <= skew_cnt + 1'b1;
      end
    end else if (sof1 | sof2) begin
      seen1    <= sof1;
      seen2    <= sof2;
      skew_cnt <= CWIDTH'(1);
    end
  end

endmodule

// File: rtl/dual_stream_rd_ctrl.sv
// Read-side scheduler: aligns both channels' frames, then issues lock-step
// line bursts with a horizontal blank and produces the merged stream framing.
module dual_stream_rd_ctrl
  import dual_stream_pkg::*;
#(
  parameter int LINE_W   = DEF_LINE_W,
  parameter int FRAME_H  = DEF_FRAME_H,
  parameter int HBLANK   = DEF_HBLANK,
  parameter int SKEW_MAX = 4095,
  parameter int CWIDTH   = 12,
  parameter int DEPTH    = 4096
) (
  input  logic              pixclk,
  input  logic              rst,
  input  logic              en,
  input  logic              sof1,
  input  logic              sof2,
  input  logic [CWIDTH-1:0] level1,
  input  logic [CWIDTH-1:0] level2,
  output logic              rd_en,
  output logic              o_image_vs,
  output logic              o_image_hs,
  output logic              o_image_valid,
  output logic [CWIDTH-1:0] line_cnt,
  output logic              skew_err,
  output logic              sof_err,
  output logic              ovf_warn,
  output logic              busy,
  output state_t            state
);

  localparam logic [CWIDTH-1:0] LINE_C    = CWIDTH'(LINE_W);
  localparam logic [CWIDTH-1:0] LAST_PIX  = CWIDTH'(LINE_W - 1);
  localparam logic [CWIDTH-1:0] LAST_GAP  = CWIDTH'(HBLANK - 1);
  localparam logic [CWIDTH-1:0] LAST_LINE = CWIDTH'(FRAME_H - 1);
  localparam logic [CWIDTH-1:0] FULL_C    = CWIDTH'(DEPTH - 1);

  logic              both_sof;
  logic              line_ready;
  logic [CWIDTH-1:0] pix_cnt;
  logic [CWIDTH-1:0] gap_cnt;

  assign line_ready = (level1 >= LINE_C) && (level2 >= LINE_C);
  assign busy       = (state != IDLE);

  sof_pair_sync #(
    .CWIDTH  (CWIDTH),
    .SKEW_MAX(SKEW_MAX)
  ) u_sof_pair_sync (
    .clk     (pixclk),
    .rst     (rst),
    .active  (state == WAIT_SOF),
    .sof1    (sof1),
    .sof2    (sof2),
    .both_sof(both_sof),
    .skew_err(skew_err)
  );

  always_ff @(posedge pixclk) begin
    if (rst) begin
      state         <= IDLE;
      rd_en         <= 1'b0;
      o_image_vs    <= 1'b0;
      o_image_hs    <= 1'b0;
      o_image_valid <= 1'b0;
      line_cnt      <= '0;
      pix_cnt       <= '0;
      gap_cnt       <= '0;
      sof_err       <= 1'b0;
      ovf_warn      <= 1'b0;
    end else begin
      o_image_vs    <= 1'b0;
      o_image_valid <= rd_en;
      o_image_hs    <= rd_en;
      if ((sof1 | sof2) && (state == WAIT_LINE || state == READ || state == GAP))
        sof_err <= 1'b1;
      if (level1 >= FULL_C || level2 >= FULL_C)
        ovf_warn <= 1'b1;

      case (state)
        IDLE: if (en) state <= WAIT_SOF;
        WAIT_SOF: begin
          if (both_sof) begin
            o_image_vs <= 1'b1;
            line_cnt   <= '0;
            state      <= WAIT_LINE;
          end
        end
        WAIT_LINE: begin
          if (line_ready) begin
            rd_en   <= 1'b1;
            pix_cnt <= '0;
            state   <= READ;
          end
        end
        READ: begin
          if (pix_cnt == LAST_PIX) begin
            rd_en   <= 1'b0;
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == LAST_GAP) begin
            // A truncated frame keeps line_cnt until the next frame start.
            if (!en) begin
              state <= IDLE;
            end else if (line_cnt == LAST_LINE) begin
              state <= WAIT_SOF;
            end else begin
              line_cnt <= line_cnt + 1'b1;
              // WAIT_LINE takes zero cycles when the next line is already buffered.
              if (line_ready) begin
                rd_en   <= 1'b1;
                pix_cnt <= '0;
                state   <= READ;
              end else begin
                state <= WAIT_LINE;
              end
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
